usb_serial_fifo_ep: RTL and testbench

Buffered, packetising serial endpoint bridge between the USB device core's OUT/IN endpoint interfaces and a byte-stream UART-style client. It replaces single-byte glue with parametrised RX and TX FIFOs, real backpressure in both directions, full-packet IN transfers, idle-timeout flushing and zero-length-packet termination. Sits between the USB protocol engine's endpoint arbiter and the serial client, all in the `clk` domain.

---
 rtl/usb_serial_pkg.sv | 30 +++
 rtl/usb_sync_fifo.sv | 65 ++++++
 rtl/usb_serial_fifo_ep.sv | 173 +++++++++++++++++
 tb/tb_usb_serial_fifo_ep.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_serial_pkg.sv
// usb_serial_pkg
//   Shared types and width helpers for the USB serial endpoint bridge.
//   in_state_t : IN endpoint packetiser states.
//   cnt_w      : occupancy counter width for a FIFO of the given depth.
//   ptr_w      : read/write pointer width for a FIFO of the given depth.
//   timer_w    : width of a counter that must hold values 0..cycles.
package usb_serial_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_REQ  = 2'd1,
        IN_FILL = 2'd2,
        IN_DONE = 2'd3
    } in_state_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int timer_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/usb_sync_fifo.sv
// usb_sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is visible on
//   rd_data whenever empty is low; rd_en pops it.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   wr_en, wr_data   : push request and data (accepted when not full, or
//                      when full but popping in the same cycle)
//   rd_en            : pop request (ignored when empty)
//   rd_data          : current head entry
//   count            : occupancy, 0..DEPTH
//   full, empty      : occupancy flags
module usb_sync_fifo
    import usb_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // A pop frees the slot this cycle, so a push alongside it is safe when full.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/usb_serial_fifo_ep.sv
// usb_serial_fifo_ep
//   Buffered bridge between the USB core's OUT/IN endpoint interfaces and a
//   byte-stream serial client. OUT bytes land in an RX FIFO read by the client
//   with valid/ready; client bytes fill a TX FIFO that is packetised into IN
//   transfers (full packets immediately, partial packets after an idle
//   timeout, zero-length packet after a full packet that drained the FIFO).
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   out_ep_*                          : USB OUT endpoint (host to device)
//   in_ep_*                           : USB IN endpoint (device to host)
//   uart_tx_data/strobe, uart_tx_ready: client bytes towards the host
//   uart_rx_data/valid, uart_rx_ready : host bytes towards the client
module usb_serial_fifo_ep
    import usb_serial_pkg::*;
#(
    parameter int RX_DEPTH     = 16,
    parameter int TX_DEPTH     = 64,
    parameter int MAX_PKT      = 64,
    parameter int FLUSH_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    output logic              out_ep_req,
    input  logic              out_ep_grant,
    input  logic              out_ep_data_avail,
    input  logic              out_ep_setup,
    output logic              out_ep_data_get,
    input  logic [BYTE_W-1:0] out_ep_data,
    output logic              out_ep_stall,
    input  logic              out_ep_acked,
    output logic              in_ep_req,
    input  logic              in_ep_grant,
    input  logic              in_ep_data_free,
    output logic              in_ep_data_put,
    output logic [BYTE_W-1:0] in_ep_data,
    output logic              in_ep_data_done,
    output logic              in_ep_stall,
    input  logic              in_ep_acked,
    output logic              uart_tx_ready,
    input  logic [BYTE_W-1:0] uart_tx_data,
    input  logic              uart_tx_strobe,
    output logic [BYTE_W-1:0] uart_rx_data,
    output logic              uart_rx_valid,
    input  logic              uart_rx_ready
);

    localparam int RX_CW  = cnt_w(RX_DEPTH);
    localparam int TX_CW  = cnt_w(TX_DEPTH);
    localparam int PKT_CW = cnt_w(MAX_PKT);
    localparam int TMR_W  = timer_w(FLUSH_CYCLES);

    logic              unused_inputs;
    logic              rx_full_unused;
    logic [BYTE_W-1:0] rx_head;
    logic [RX_CW-1:0]  rx_count;
    logic              rx_empty;
    logic [RX_CW:0]    rx_used;
    logic              get_q;
    logic [BYTE_W-1:0] tx_head;
    logic [TX_CW-1:0]  tx_count;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_wr;
    logic              in_put;
    in_state_t         state;
    logic [PKT_CW-1:0] pkt_cnt;
    logic              pkt_at_max;
    logic              zlp_pending;
    logic [TMR_W-1:0]  idle_timer;
    logic              full_trig;
    logic              flush_trig;

    assign unused_inputs = &{1'b0, out_ep_setup, out_ep_acked, in_ep_acked};

    assign out_ep_stall = 1'b0;
    assign in_ep_stall  = 1'b0;

    // The byte fetched by last cycle's get is still in flight, so reserve it:
    // request only while at least two slots remain free.
    assign rx_used         = {1'b0, rx_count} + (RX_CW + 1)'(get_q);
    assign out_ep_req      = out_ep_data_avail && (rx_used <= (RX_CW + 1)'(RX_DEPTH - 2));
    assign out_ep_data_get = out_ep_grant && out_ep_req;

    assign uart_rx_valid = !rx_empty;
    assign uart_rx_data  = rx_empty ? '0 : rx_head;

    usb_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (get_q),
        .wr_data (out_ep_data),
        .rd_en   (uart_rx_ready),
        .rd_data (rx_head),
        .count   (rx_count),
        .full    (rx_full_unused),
        .empty   (rx_empty)
    );

    assign uart_tx_ready = !tx_full;
    // A strobe into a full FIFO is kept only if the IN side pops that cycle.
    assign tx_wr         = uart_tx_strobe && (!tx_full || in_put);

    usb_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_wr),
        .wr_data (uart_tx_data),
        .rd_en   (in_put),
        .rd_data (tx_head),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign pkt_at_max     = (pkt_cnt == PKT_CW'(MAX_PKT));
    assign in_put         = (state == IN_FILL) && in_ep_data_free && !tx_empty && !pkt_at_max;
    assign in_ep_data_put = in_put;
    assign in_ep_data     = in_put ? tx_head : '0;

    assign full_trig  = (tx_count >= TX_CW'(MAX_PKT));
    assign flush_trig = (idle_timer == TMR_W'(FLUSH_CYCLES)) && ((tx_count != '0) || zlp_pending);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IN_IDLE;
            in_ep_req       <= 1'b0;
            in_ep_data_done <= 1'b0;
            pkt_cnt         <= '0;
            zlp_pending     <= 1'b0;
            idle_timer      <= '0;
            get_q           <= 1'b0;
        end else begin
            get_q           <= out_ep_data_get;
            in_ep_data_done <= 1'b0;
            case (state)
                IN_IDLE: begin
                    pkt_cnt <= '0;
                    if (full_trig || flush_trig) begin
                        state      <= IN_REQ;
                        in_ep_req  <= 1'b1;
                        idle_timer <= '0;
                    end else if (tx_wr) begin
                        idle_timer <= '0;
                    end else if ((!tx_empty || zlp_pending) &&
                                 (idle_timer != TMR_W'(FLUSH_CYCLES))) begin
                        idle_timer <= idle_timer + TMR_W'(1);
                    end
                end
                IN_REQ: begin
                    if (in_ep_grant) state <= IN_FILL;
                end
                IN_FILL: begin
                    if (in_put) pkt_cnt <= pkt_cnt + PKT_CW'(1);
                    // No put happens in a closing cycle, so pkt_cnt is final here.
                    if (pkt_at_max || tx_empty) begin
                        state           <= IN_DONE;
                        in_ep_data_done <= 1'b1;
                        zlp_pending     <= pkt_at_max && tx_empty;
                    end
                end
                IN_DONE: begin
                    state     <= IN_IDLE;
                    in_ep_req <= 1'b0;
                end
                default: begin
                    state     <= IN_IDLE;
                    in_ep_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_serial_fifo_ep.sv
// tb_usb_serial_fifo_ep
//   Directed bench for usb_serial_fifo_ep: OUT burst with backpressure, full
//   IN packet plus ZLP, partial flush timing, IN backpressure, TX full with
//   simultaneous write/pop, and reset in the middle of a packet.
module tb_usb_serial_fifo_ep;

    localparam int RX_DEPTH     = 16;
    localparam int TX_DEPTH     = 64;
    localparam int MAX_PKT      = 64;
    localparam int FLUSH_CYCLES = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic       out_ep_req;
    logic       out_ep_grant;
    logic       out_ep_data_avail;
    logic       out_ep_setup;
    logic       out_ep_data_get;
    logic [7:0] out_ep_data;
    logic       out_ep_stall;
    logic       out_ep_acked;
    logic       in_ep_req;
    logic       in_ep_grant;
    logic       in_ep_data_free;
    logic       in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done;
    logic       in_ep_stall;
    logic       in_ep_acked;
    logic       uart_tx_ready;
    logic [7:0] uart_tx_data;
    logic       uart_tx_strobe;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       uart_rx_ready;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    usb_serial_fifo_ep #(
        .RX_DEPTH     (RX_DEPTH),
        .TX_DEPTH     (TX_DEPTH),
        .MAX_PKT      (MAX_PKT),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .out_ep_req        (out_ep_req),
        .out_ep_grant      (out_ep_grant),
        .out_ep_data_avail (out_ep_data_avail),
        .out_ep_setup      (out_ep_setup),
        .out_ep_data_get   (out_ep_data_get),
        .out_ep_data       (out_ep_data),
        .out_ep_stall      (out_ep_stall),
        .out_ep_acked      (out_ep_acked),
        .in_ep_req         (in_ep_req),
        .in_ep_grant       (in_ep_grant),
        .in_ep_data_free   (in_ep_data_free),
        .in_ep_data_put    (in_ep_data_put),
        .in_ep_data        (in_ep_data),
        .in_ep_data_done   (in_ep_data_done),
        .in_ep_stall       (in_ep_stall),
        .in_ep_acked       (in_ep_acked),
        .uart_tx_ready     (uart_tx_ready),
        .uart_tx_data      (uart_tx_data),
        .uart_tx_strobe    (uart_tx_strobe),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_ready     (uart_rx_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        uart_tx_strobe = 1'b0;
    endtask

    task automatic strobe_bytes(input int n, input int base, input int step);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            uart_tx_strobe = 1'b1;
            uart_tx_data   = 8'(base + i * step);
            exp_q.push_back(8'(base + i * step));
        end
    endtask

    task automatic wait_req(input int limit, output int cyc, output bit found);
        cyc   = 0;
        found = 1'b0;
        while (!found && cyc < limit) begin
            next_cycle();
            cyc++;
            #1;
            if (in_ep_req) found = 1'b1;
        end
    endtask

    // Runs an IN transfer already granted; collects puts until the done pulse.
    task automatic collect(input bit toggle, output int puts, output bit done_seen);
        logic [7:0] eb;
        int c;
        puts      = 0;
        done_seen = 1'b0;
        c         = 0;
        while (!done_seen && c < 400) begin
            next_cycle();
            in_ep_data_free = toggle ? (c % 2 == 0) : 1'b1;
            c++;
            #1;
            if (in_ep_data_put) begin
                check("put_needs_free", in_ep_data_free, 1);
                eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                check("in_data", in_ep_data, eb);
                puts++;
            end
            if (in_ep_data_done) begin
                done_seen = 1'b1;
                check("req_during_done", in_ep_req, 1);
            end
        end
        in_ep_grant     = 1'b0;
        in_ep_data_free = 1'b0;
        next_cycle();
        #1;
        check("done_one_cycle", in_ep_data_done, 0);
        check("req_drop_after_done", in_ep_req, 0);
    endtask

    initial begin
        int  cyc;
        int  puts;
        bit  found;
        bit  done_seen;
        int  gets;
        bit  pend;
        int  pend_val;
        int  rx_idx;
        int  first_get;
        int  first_valid;
        int  bad_evt;

        reset             = 1'b1;
        out_ep_grant      = 1'b0;
        out_ep_data_avail = 1'b0;
        out_ep_setup      = 1'b0;
        out_ep_data       = 8'h00;
        out_ep_acked      = 1'b0;
        in_ep_grant       = 1'b0;
        in_ep_data_free   = 1'b0;
        in_ep_acked       = 1'b0;
        uart_tx_data      = 8'h00;
        uart_tx_strobe    = 1'b0;
        uart_rx_ready     = 1'b0;

        // Reset state
        repeat (3) next_cycle();
        reset = 1'b0;
        #1;
        check("rst_out_req",   out_ep_req, 0);
        check("rst_out_get",   out_ep_data_get, 0);
        check("rst_stalls",    {out_ep_stall, in_ep_stall}, 0);
        check("rst_in_req",    in_ep_req, 0);
        check("rst_in_put",    in_ep_data_put, 0);
        check("rst_in_data",   in_ep_data, 0);
        check("rst_in_done",   in_ep_data_done, 0);
        check("rst_tx_ready",  uart_tx_ready, 1);
        check("rst_rx_valid",  uart_rx_valid, 0);
        check("rst_rx_data",   uart_rx_data, 0);

        // OUT burst: 20 bytes, client stalled for 40 cycles
        gets        = 0;
        pend        = 1'b0;
        pend_val    = 0;
        rx_idx      = 0;
        first_get   = -1;
        first_valid = -1;
        out_ep_grant = 1'b1;
        for (int c = 0; c < 300 && rx_idx < 20; c++) begin
            next_cycle();
            out_ep_data       = pend ? 8'(pend_val) : 8'h00;
            out_ep_data_avail = (gets < 20);
            uart_rx_ready     = (c >= 40);
            #1;
            pend = 1'b0;
            if (out_ep_data_get) begin
                if (first_get < 0) first_get = c;
                pend     = 1'b1;
                pend_val = gets;
                gets++;
            end
            if (uart_rx_valid && first_valid < 0) first_valid = c;
            if (c == 39) begin
                check("out_gets_stop_at_15", gets, 15);
                check("out_req_low_when_full", out_ep_req, 0);
                check("out_rx_valid_held", uart_rx_valid, 1);
            end
            if (uart_rx_valid && uart_rx_ready) begin
                check("rx_data_order", uart_rx_data, rx_idx);
                rx_idx++;
            end
        end
        check("out_grant_to_valid", first_valid - first_get, 2);
        check("out_total_gets", gets, 20);
        check("rx_total_bytes", rx_idx, 20);
        out_ep_grant      = 1'b0;
        out_ep_data_avail = 1'b0;
        uart_rx_ready     = 1'b0;

        // Full IN packet, then ZLP after the idle timeout
        strobe_bytes(64, 0, 1);
        wait_req(100, cyc, found);
        check("full_req_found", found, 1);
        check("full_req_latency", cyc, 2);
        in_ep_grant = 1'b1;
        collect(1'b0, puts, done_seen);
        check("full_puts", puts, 64);
        check("full_done", done_seen, 1);
        check("zlp_set_after_full", dut.zlp_pending, 1);
        wait_req(FLUSH_CYCLES + 50, cyc, found);
        check("zlp_req_found", found, 1);
        in_ep_grant = 1'b1;
        collect(1'b0, puts, done_seen);
        check("zlp_puts", puts, 0);
        check("zlp_done", done_seen, 1);
        check("zlp_cleared", dut.zlp_pending, 0);

        // Partial flush: 5 bytes then idle
        strobe_bytes(5, 8'h50, 1);
        wait_req(FLUSH_CYCLES + 50, cyc, found);
        check("flush_req_found", found, 1);
        check("flush_latency", cyc, FLUSH_CYCLES + 2);
        in_ep_grant = 1'b1;
        collect(1'b0, puts, done_seen);
        check("flush_puts", puts, 5);
        check("flush_done", done_seen, 1);
        bad_evt = 0;
        for (int c = 0; c < FLUSH_CYCLES + 20; c++) begin
            next_cycle();
            #1;
            if (in_ep_req || in_ep_data_done) bad_evt++;
        end
        check("no_zlp_after_short", bad_evt, 0);

        // IN backpressure: free toggles every other cycle
        strobe_bytes(64, 3, 7);
        wait_req(100, cyc, found);
        check("bp_req_found", found, 1);
        in_ep_grant = 1'b1;
        collect(1'b1, puts, done_seen);
        check("bp_puts", puts, 64);
        check("bp_done", done_seen, 1);
        wait_req(FLUSH_CYCLES + 50, cyc, found);
        check("bp_zlp_req_found", found, 1);
        in_ep_grant = 1'b1;
        collect(1'b0, puts, done_seen);
        check("bp_zlp_puts", puts, 0);

        // TX full: 64 bytes with no grant, 65th dropped, write+pop when full
        strobe_bytes(64, 8'hC0, 1);
        wait_req(100, cyc, found);
        check("txf_req_found", found, 1);
        check("txf_ready_low", uart_tx_ready, 0);
        next_cycle();
        uart_tx_strobe = 1'b1;
        uart_tx_data   = 8'hEE;
        #1;
        check("txf_no_put_ungranted", in_ep_data_put, 0);
        next_cycle();
        in_ep_grant = 1'b1;
        #1;
        check("txf_ready_low_after_drop", uart_tx_ready, 0);
        next_cycle();
        in_ep_data_free = 1'b1;
        uart_tx_strobe  = 1'b1;
        uart_tx_data    = 8'h77;
        #1;
        check("txf_first_put", in_ep_data_put, 1);
        check("txf_first_data", in_ep_data, 8'hC0);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h77);
        next_cycle();
        in_ep_data_free = 1'b1;
        #1;
        check("txf_count_held_full", uart_tx_ready, 0);
        check("txf_second_data", in_ep_data, 8'hC1);
        void'(exp_q.pop_front());
        collect(1'b0, puts, done_seen);
        check("txf_puts", puts + 2, 64);
        check("txf_no_zlp", dut.zlp_pending, 0);
        wait_req(FLUSH_CYCLES + 50, cyc, found);
        check("txf_tail_req_found", found, 1);
        in_ep_grant = 1'b1;
        collect(1'b0, puts, done_seen);
        check("txf_tail_puts", puts, 1);

        // Reset in the middle of FILL after 10 puts
        strobe_bytes(64, 8'h20, 1);
        wait_req(100, cyc, found);
        check("rstm_req_found", found, 1);
        in_ep_grant = 1'b1;
        puts = 0;
        for (int c = 0; c < 100 && puts < 10; c++) begin
            next_cycle();
            in_ep_data_free = 1'b1;
            #1;
            if (in_ep_data_put) puts++;
        end
        check("rstm_puts_before", puts, 10);
        next_cycle();
        reset           = 1'b1;
        in_ep_grant     = 1'b0;
        in_ep_data_free = 1'b0;
        next_cycle();
        reset = 1'b0;
        #1;
        check("rstm_in_req",   in_ep_req, 0);
        check("rstm_in_done",  in_ep_data_done, 0);
        check("rstm_in_put",   in_ep_data_put, 0);
        check("rstm_in_data",  in_ep_data, 0);
        check("rstm_tx_ready", uart_tx_ready, 1);
        check("rstm_rx_valid", uart_rx_valid, 0);
        exp_q.delete();
        bad_evt = 0;
        for (int c = 0; c < FLUSH_CYCLES + 20; c++) begin
            next_cycle();
            #1;
            if (in_ep_req || in_ep_data_done || !uart_tx_ready) bad_evt++;
        end
        check("rstm_quiet_after", bad_evt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
